score_stream_sorter: RTL and testbench

SCORE_STREAM_SORTER -- requirements
Module: score_stream_sorter

---
 rtl/score_stream_sorter.sv | 149 ++++++++++++++
 tb/tb_score_stream_sorter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/score_stream_sorter.sv
// Collects a 7-score frame, sorts (score, id) pairs with an odd-even transposition
// network (one pass per cycle), then streams the ranked pairs out one per cycle.
module score_stream_sorter (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_score,
  input  logic [1:0] opt,
  output logic       out_valid,
  output logic [2:0] out_id,
  output logic [3:0] out_score,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SORT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] opt_q, opt_d;
  logic [3:0] score_q [7];
  logic [3:0] score_d [7];
  logic [2:0] id_q    [7];
  logic [2:0] id_d    [7];
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_id_q, out_id_d;
  logic [3:0] out_score_q, out_score_d;

  logic [3:0] score_sw [7];
  logic [2:0] id_sw    [7];

  // opt bit0 selects signed keys, bit1 selects descending order; ties never swap.
  function automatic logic out_of_order(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] o);
    logic signed [4:0] ka;
    logic signed [4:0] kb;
    ka = o[0] ? {a[3], a} : {1'b0, a};
    kb = o[0] ? {b[3], b} : {1'b0, b};
    return o[1] ? (ka < kb) : (ka > kb);
  endfunction

  // One transposition pass; even passes start at pair (0,1), odd at (1,2).
  always_comb begin
    score_sw = score_q;
    id_sw    = id_q;
    for (int i = 0; i < 6; i++) begin
      if ((i[0] == cnt_q[0]) && out_of_order(score_q[i], score_q[i+1], opt_q)) begin
        score_sw[i]   = score_q[i+1];
        score_sw[i+1] = score_q[i];
        id_sw[i]      = id_q[i+1];
        id_sw[i+1]    = id_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opt_d       = opt_q;
    score_d     = score_q;
    id_d        = id_q;
    out_valid_d = 1'b0;
    out_id_d    = 3'd0;
    out_score_d = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          score_d[0] = in_score;
          id_d[0]    = 3'd0;
          opt_d      = opt;
          cnt_d      = 3'd1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!in_valid) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          score_d[cnt_q] = in_score;
          id_d[cnt_q]    = cnt_q;
          if (cnt_q == 3'd6) begin
            state_d = S_SORT;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_SORT: begin
        score_d = score_sw;
        id_d    = id_sw;
        // The final pass result feeds rank 0 directly so output starts without a bubble.
        if (cnt_q == 3'd6) begin
          state_d     = S_OUT;
          cnt_d       = 3'd0;
          out_valid_d = 1'b1;
          out_id_d    = id_sw[0];
          out_score_d = score_sw[0];
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        if (cnt_q == 3'd6) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d       = cnt_q + 3'd1;
          out_valid_d = 1'b1;
          out_id_d    = id_q[cnt_q + 3'd1];
          out_score_d = score_q[cnt_q + 3'd1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      opt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_id_q    <= 3'd0;
      out_score_q <= 4'd0;
      for (int i = 0; i < 7; i++) begin
        score_q[i] <= 4'd0;
        id_q[i]    <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opt_q       <= opt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_score_q <= out_score_d;
      score_q     <= score_d;
      id_q        <= id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_score = out_score_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_stream_sorter.sv
// Directed bench for score_stream_sorter: fixed frames with hand-computed rankings.
module tb_score_stream_sorter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_score;
  logic [1:0] opt;
  logic       out_valid;
  logic [2:0] out_id;
  logic [3:0] out_score;
  logic       busy;

  int checks;
  int errors;

  logic [3:0] cur_sc [7];
  logic [2:0] exp_id [7];
  logic [3:0] exp_sc [7];

  score_stream_sorter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_score  (in_score),
    .opt       (opt),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_score (out_score),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // opt is only meaningful on the first cycle; later cycles carry its complement.
  task automatic send_frame(input logic [1:0] o, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_score = cur_sc[k];
      opt      = (k == 0) ? o : ~o;
      tick();
    end
    in_valid = 1'b0;
    in_score = 4'd0;
    opt      = 2'd0;
  endtask

  // Called right after the last input edge (cycle T+1); returns in cycle T+15.
  task automatic check_frame(input string tag);
    for (int c = 1; c <= 7; c++) begin
      chk({tag, " sort_valid"}, {7'd0, out_valid}, 8'd0);
      chk({tag, " sort_busy"}, {7'd0, busy}, 8'd1);
      tick();
    end
    for (int r = 0; r < 7; r++) begin
      chk({tag, " out_valid"}, {7'd0, out_valid}, 8'd1);
      chk({tag, " out_id"}, {5'd0, out_id}, {5'd0, exp_id[r]});
      chk({tag, " out_score"}, {4'd0, out_score}, {4'd0, exp_sc[r]});
      tick();
    end
    chk({tag, " end_valid"}, {7'd0, out_valid}, 8'd0);
    chk({tag, " end_id"}, {5'd0, out_id}, 8'd0);
    chk({tag, " end_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_score = 4'd0;
    opt      = 2'd0;
    #2;
    chk("rst out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst out_id", {5'd0, out_id}, 8'd0);
    chk("rst out_score", {4'd0, out_score}, 8'd0);
    chk("rst busy", {7'd0, busy}, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Unsigned ascending.
    cur_sc = '{4'd8, 4'd11, 4'd8, 4'd0, 4'd5, 4'd14, 4'd7};
    exp_id = '{3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd1, 3'd5};
    exp_sc = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd8, 4'd11, 4'd14};
    send_frame(2'b00, 7);
    check_frame("u_asc");
    tick();

    // Signed ascending: 8,11,14 are -8,-5,-2.
    exp_id = '{3'd0, 3'd2, 3'd1, 3'd5, 3'd3, 3'd4, 3'd6};
    exp_sc = '{4'd8, 4'd8, 4'd11, 4'd14, 4'd0, 4'd5, 4'd7};
    send_frame(2'b01, 7);
    check_frame("s_asc");

    // Unsigned descending, started back-to-back at T+15.
    exp_id = '{3'd5, 3'd1, 3'd0, 3'd2, 3'd6, 3'd4, 3'd3};
    exp_sc = '{4'd14, 4'd11, 4'd8, 4'd8, 4'd7, 4'd5, 4'd0};
    send_frame(2'b10, 7);
    check_frame("u_desc_b2b");
    tick();

    // All ties, descending: ids must stay in load order.
    cur_sc = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    exp_id = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    exp_sc = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    send_frame(2'b10, 7);
    check_frame("ties");
    tick();

    // Signed descending with extremes: 7,-8,0,-1,-8,1,7.
    cur_sc = '{4'd7, 4'd8, 4'd0, 4'd15, 4'd8, 4'd1, 4'd7};
    exp_id = '{3'd0, 3'd6, 3'd5, 3'd2, 3'd3, 3'd1, 3'd4};
    exp_sc = '{4'd7, 4'd7, 4'd1, 4'd0, 4'd15, 4'd8, 4'd8};
    send_frame(2'b11, 7);
    check_frame("s_desc");
    tick();

    // Abort after 4 scores.
    cur_sc = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(2'b00, 4);
    chk("abort busy_before", {7'd0, busy}, 8'd1);
    tick();
    chk("abort busy_after", {7'd0, busy}, 8'd0);
    for (int c = 0; c < 16; c++) begin
      chk("abort no_out", {7'd0, out_valid}, 8'd0);
      tick();
    end
    cur_sc = '{4'd8, 4'd11, 4'd8, 4'd0, 4'd5, 4'd14, 4'd7};
    exp_id = '{3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd1, 3'd5};
    exp_sc = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd8, 4'd11, 4'd14};
    send_frame(2'b00, 7);
    check_frame("after_abort");
    tick();

    // Reset pulse while rank 3 is on the outputs.
    send_frame(2'b00, 7);
    for (int c = 0; c < 10; c++) tick();
    chk("pre_rst valid", {7'd0, out_valid}, 8'd1);
    chk("pre_rst id", {5'd0, out_id}, 8'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid valid", {7'd0, out_valid}, 8'd0);
    chk("rst_mid id", {5'd0, out_id}, 8'd0);
    chk("rst_mid score", {4'd0, out_score}, 8'd0);
    chk("rst_mid busy", {7'd0, busy}, 8'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("post_rst no_out", {7'd0, out_valid}, 8'd0);
      chk("post_rst busy", {7'd0, busy}, 8'd0);
      tick();
    end

    // Clean run followed by a back-to-back frame at T+15.
    exp_id = '{3'd0, 3'd2, 3'd1, 3'd5, 3'd3, 3'd4, 3'd6};
    exp_sc = '{4'd8, 4'd8, 4'd11, 4'd14, 4'd0, 4'd5, 4'd7};
    send_frame(2'b01, 7);
    check_frame("post_rst_run");
    exp_id = '{3'd5, 3'd1, 3'd0, 3'd2, 3'd6, 3'd4, 3'd3};
    exp_sc = '{4'd14, 4'd11, 4'd8, 4'd8, 4'd7, 4'd5, 4'd0};
    send_frame(2'b10, 7);
    check_frame("post_rst_b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
